// File: rtl/regfile_dump.sv
// regfile_dump: sequential reader for the 32x32 CPU register file.
//
// On a start pulse in IDLE the block walks r0..r(NREG-1) through one register-file read port
// (rd_addr/rd_data) and streams each word out on a valid/ready channel. The core must be stalled
// while busy is high; this block does not arbitrate the read port.
//
// Ports:
//   clk        system clock, all state updates on posedge
//   rst        asynchronous active-low reset
//   start      single-cycle dump request, honoured only in IDLE
//   busy       high in READ, SEND and FIN
//   done       one-cycle pulse after the last beat handshakes
//   rd_addr    register-file read address (0 outside READ)
//   rd_data    combinational read data for rd_addr
//   out_valid  out_index/out_data hold a beat
//   out_ready  downstream accepts the beat this cycle
//   out_index  register number of the current beat
//   out_data   register contents of the current beat
//   checksum   running XOR of all handed-off words (only with DUMP_CHECKSUM_EN)
//
// Optional feature macro: DUMP_CHECKSUM_EN adds the checksum output and accumulator.

module regfile_dump #(
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_index,
  output logic [DW-1:0] out_data
`ifdef DUMP_CHECKSUM_EN
  ,
  output logic [DW-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StSend,
    StFin
  } state_e;

  localparam logic [AW-1:0] LastIdx = AW'(NREG - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] out_index_q, out_index_d;
  logic [DW-1:0] out_data_q, out_data_d;
`ifdef DUMP_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
`ifdef DUMP_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    busy        = 1'b0;
    done        = 1'b0;
    out_valid   = 1'b0;
    rd_addr     = '0;

    case (state_q)
      StIdle: begin
        if (start) begin
          idx_d   = '0;
          state_d = StRead;
`ifdef DUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      StRead: begin
        busy        = 1'b1;
        rd_addr     = idx_q;
        // Capture the word so the beat stays stable even if the register file changes.
        out_data_d  = rd_data;
        out_index_d = idx_q;
        state_d     = StSend;
      end
      StSend: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
`ifdef DUMP_CHECKSUM_EN
          csum_d = csum_q ^ out_data_q;
`endif
          // Terminal-count compare keeps idx from ever passing NREG-1.
          if (idx_q == LastIdx) begin
            state_d = StFin;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StRead;
          end
        end
      end
      StFin: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      out_index_q <= '0;
      out_data_q  <= '0;
`ifdef DUMP_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
`ifdef DUMP_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign out_index = out_index_q;
  assign out_data  = out_data_q;
`ifdef DUMP_CHECKSUM_EN
  assign checksum  = csum_q;
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: table of dump scenarios checked against a snapshot
// model of the register file, plus a hand-written mid-dump reset sequence.

module tb_regfile_dump;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_index;
  logic [DW-1:0] out_data;
`ifdef DUMP_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  logic [DW-1:0] rf [NREG];
  assign rd_data = rf[rd_addr];

  always #5 clk = ~clk;

  regfile_dump #(
    .NREG(NREG),
    .AW  (AW),
    .DW  (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
`ifdef DUMP_CHECKSUM_EN
    .checksum (checksum),
`endif
    .out_data (out_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // pattern: 0 = 1000_0000+i, 1 = random, 2 = i, 3 = all ones except r0 = 0
  typedef struct {
    int pattern;
    int ready_pct;
    int stall_beat;
    int restart_beat;
    int exp_beats;
    int exp_ndone;
    int exp_done_cyc;
  } vec_t;

  vec_t tbl[8];

  task automatic load_pattern(input int p);
    for (int i = 0; i < NREG; i++) begin
      case (p)
        0:       rf[i] = 32'h1000_0000 + 32'(i);
        1:       rf[i] = $urandom;
        2:       rf[i] = 32'(i);
        default: rf[i] = (i == 0) ? 32'h0 : 32'hFFFF_FFFF;
      endcase
    end
  endtask

  // Starts a dump in the current (IDLE) cycle and follows it until busy drops.
  task automatic run_dump(input vec_t v);
    logic [31:0]   exp_word [NREG];
    logic [31:0]   exp_x;
    int            beat, ndone, done_cyc, first_valid, stall_left;
    bit            prev_stall, restarted;
    logic [AW-1:0] prev_idx;
    logic [31:0]   prev_data;

    load_pattern(v.pattern);
    exp_x = '0;
    for (int i = 0; i < NREG; i++) begin
      exp_word[i] = rf[i];
      exp_x       = exp_x ^ rf[i];
    end
    beat = 0; ndone = 0; done_cyc = -1; first_valid = -1; stall_left = 5;
    prev_stall = 1'b0; restarted = 1'b0; prev_idx = '0; prev_data = '0;

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      start = 1'b0;
      if (cyc == 0) check("busy_after_start", {31'b0, busy}, 32'd1);
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall) begin
        check("stall_valid", {31'b0, out_valid}, 32'd1);
        check("stall_index", {27'b0, out_index}, {27'b0, prev_idx});
        check("stall_data", out_data, prev_data);
      end
      if (busy && !out_valid && !done) check("read_addr", {27'b0, rd_addr}, 32'(beat));
      if (done) begin
        ndone++;
        done_cyc = cyc;
`ifdef DUMP_CHECKSUM_EN
        check("checksum", checksum, exp_x);
`endif
      end
      if (!busy) break;

      out_ready = ($urandom_range(99) < 32'(v.ready_pct));
      if (out_valid && beat == v.stall_beat && stall_left > 0) begin
        out_ready = 1'b0;
        // Rewrite the already-captured register while the beat is held.
        if (stall_left == 5) rf[beat] = 32'hDEAD_BEEF;
        stall_left--;
      end
      if (out_valid && beat == v.restart_beat && !restarted) begin
        start     = 1'b1;
        restarted = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_idx   = out_index;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        check("beat_index", {27'b0, out_index}, 32'(beat));
        if (beat < NREG) check("beat_data", out_data, exp_word[beat]);
        else check("extra_beat", 32'(beat), 32'(NREG - 1));
        beat++;
      end
      @(posedge clk); #1;
    end

    check("idle_after_dump", {31'b0, busy}, 32'd0);
    check("beat_count", 32'(beat), 32'(v.exp_beats));
    check("done_count", 32'(ndone), 32'(v.exp_ndone));
    check("first_valid_cyc", 32'(first_valid), 32'd1);
    if (v.exp_done_cyc >= 0) check("done_cyc", 32'(done_cyc), 32'(v.exp_done_cyc));
    check("idle_rd_addr", {27'b0, rd_addr}, 32'd0);
    check("idle_valid", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst       = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    load_pattern(0);

    tbl[0] = '{0, 100, -1, -1, 32, 1, 64};
    tbl[1] = '{0, 100, -1, -1, 32, 1, 64};  // back-to-back, identical data
    tbl[2] = '{0, 100,  3, -1, 32, 1, 69};  // 5-cycle stall on beat 3
    tbl[3] = '{0, 100, -1, 10, 32, 1, 64};  // start ignored while busy
    tbl[4] = '{1,  50, -1, -1, 32, 1, -1};
    tbl[5] = '{1,  25,  7, 20, 32, 1, -1};
    tbl[6] = '{2, 100, -1, -1, 32, 1, 64};
    tbl[7] = '{3,  70, -1, -1, 32, 1, -1};

    #7;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_index", {27'b0, out_index}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_rd_addr", {27'b0, rd_addr}, 32'd0);
`ifdef DUMP_CHECKSUM_EN
    check("rst_checksum", checksum, 32'd0);
`endif
    @(posedge clk); #4;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 8; t++) run_dump(tbl[t]);

    // Mid-dump reset on beat 7, then a fresh dump must start from index 0.
    load_pattern(0);
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (k < 100 && !(out_valid && out_index == 5'd7)) begin
      @(posedge clk); #1;
      k++;
    end
    check("abort_reach_beat7", {27'b0, out_index}, 32'd7);
    #3 rst = 1'b0;
    #1;
    check("abort_valid", {31'b0, out_valid}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_index", {27'b0, out_index}, 32'd0);
    check("abort_data", out_data, 32'd0);
    @(posedge clk); #4;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("post_abort_valid", {31'b0, out_valid}, 32'd0);
      check("post_abort_busy", {31'b0, busy}, 32'd0);
      check("post_abort_done", {31'b0, done}, 32'd0);
    end
    run_dump(tbl[0]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Sequential reader for the CPU's 32x32 register file. On a start pulse it walks r0..r31 through one register-file read port and streams each word out on a valid/ready channel.
- Used for debug/test readout of architectural state after a program halts, driven by the testbench or a debug UART bridge.
- Sits beside the register file and drives its rs address input while a dump is active. The core must be stalled during a dump; this block does not arbitrate the port.

Parameters:
NREG, 32, number of registers walked (indices 0..NREG-1)
AW, 5, register address width (2^AW >= NREG)
DW, 32, register data width

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  asynchronous active-low reset (0 = reset asserted)
start  input  1  single-cycle request to begin a dump; honoured only in IDLE
busy  output  1  high from the cycle after start is accepted until DONE exits
done  output  1  one-cycle pulse after the last beat handshakes
rd_addr  output  AW  address to register-file read port (rs)
rd_data  input  DW  combinational read data returned for rd_addr
out_valid  output  1  out_index/out_data hold a beat
out_ready  input  1  downstream accepts the beat this cycle
out_index  output  AW  register number of the current beat
out_data  output  DW  register contents of the current beat

Behaviour:
- Reset (rst=0, async) forces:
  - state=IDLE, idx=0, rd_addr=0.
  - busy=0, done=0, out_valid=0, out_index=0, out_data=0.
- Reset asserted mid-dump aborts immediately. No done pulse is produced and no partial beat remains valid after release.
- FSM states: IDLE, READ, SEND, FIN.
- IDLE:
  - rd_addr=0.
  - start=1 -> idx<=0, go to READ.
  - Any other cycle -> stay in IDLE.
- READ:
  - rd_addr=idx.
  - At the clock edge: out_data<=rd_data, out_index<=idx, go to SEND.
- SEND:
  - out_valid=1. out_data and out_index are registered and stay stable until the handshake, even if the register file changes.
  - Handshake = out_valid & out_ready.
  - On handshake with idx==NREG-1 -> go to FIN.
  - On handshake otherwise -> idx<=idx+1, go to READ.
  - No handshake -> stay in SEND, outputs unchanged.
- FIN:
  - done=1 for exactly this one cycle, then go to IDLE.
- busy=1 in READ, SEND and FIN; busy=0 in IDLE.
- start while not in IDLE is ignored: no restart, no queuing.
- Latency:
  - start sampled at edge T -> READ in cycle T+1 -> first out_valid in cycle T+2.
  - With out_ready held high, each beat takes 2 cycles.
  - A full 32-register dump takes 64 cycles from READ entry to the FIN edge.
- idx is AW bits wide. The terminal-count compare against NREG-1 prevents wrap-around, so idx never passes NREG-1.
- out_valid never deasserts without a handshake, except through reset.
- rd_addr changes only on clock edges (registered FSM), so the read port sees a stable address for the whole READ cycle.

Optional Feature:
- Macro DUMP_CHECKSUM_EN.
- Defined:
  - Adds output port checksum [DW-1:0].
  - A running XOR of every out_data word is accumulated on each handshake.
  - The accumulator clears to 0 on reset and when start is accepted.
  - checksum is valid and stable from the done cycle until the next accepted start.
- Undefined:
  - The checksum port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Preload r[i]=32'h1000_0000+i, pulse start with out_ready=1 -> 32 beats with out_index 0..31 and out_data 32'h1000_0000..32'h1000_001F in order; first out_valid 2 cycles after start; done pulses once, 64 cycles after READ entry; busy=0 afterwards.
- Backpressure: out_ready=0 for 5 cycles on beat 3 while r3 is rewritten to 32'hDEAD_BEEF -> out_valid stays 1 and out_data stays the original 32'h1000_0003; the stream resumes at index 4 when out_ready returns to 1.
- start pulsed again at beat 10 -> ignored; the sequence continues to 31 with exactly one done pulse.
- rst driven low at beat 7 for 1 cycle, asynchronously mid-cycle -> out_valid, busy and done drop immediately; after release a new start dumps from index 0.
- Back-to-back: start asserted in the cycle right after done -> second dump begins normally with identical data.
- DUMP_CHECKSUM_EN defined, r[i]=i for all i -> checksum=32'h0000_0000 at done; with r[i]=32'hFFFF_FFFF except r0=0 -> checksum=32'hFFFF_FFFF.
